// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// default bus widths and the depth of the decoder-facing queue.
package fetch_pkg;

    localparam int FETCH_ADDR_WIDTH = 9;
    localparam int FETCH_DATA_WIDTH = 16;
    localparam int QUEUE_DEPTH      = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {instr, pc} FIFO between code memory capture and the decoder.
// The head entry is itself a register, so the decoder sees registered values.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter int DATA_WIDTH = FETCH_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_instr,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_instr,
    output logic [ADDR_WIDTH-1:0] head_pc,
    output logic [1:0]            count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] head_instr_r;
    logic [ADDR_WIDTH-1:0] head_pc_r;
    logic [DATA_WIDTH-1:0] tail_instr_r;
    logic [ADDR_WIDTH-1:0] tail_pc_r;
    logic [1:0]            count_r;
    logic                  push_s;
    logic                  pop_s;

    assign empty      = (count_r == 2'd0);
    assign full       = (count_r == 2'(QUEUE_DEPTH));
    assign count      = count_r;
    assign head_instr = head_instr_r;
    assign head_pc    = head_pc_r;

    // A pop from empty or a push into a full queue without a pop is dropped.
    assign pop_s  = pop && !empty;
    assign push_s = push && (!full || pop_s);

    // Queue storage: head/tail shift structure with flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_instr_r <= '0;
            head_pc_r    <= '0;
            tail_instr_r <= '0;
            tail_pc_r    <= '0;
            count_r      <= 2'd0;
        end else if (flush) begin
            count_r <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_instr_r <= push_instr;
                        head_pc_r    <= push_pc;
                    end else begin
                        tail_instr_r <= push_instr;
                        tail_pc_r    <= push_pc;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    head_instr_r <= tail_instr_r;
                    head_pc_r    <= tail_pc_r;
                    count_r      <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_instr_r <= push_instr;
                        head_pc_r    <= push_pc;
                    end else begin
                        head_instr_r <= tail_instr_r;
                        head_pc_r    <= tail_pc_r;
                        tail_instr_r <= push_instr;
                        tail_pc_r    <= push_pc;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues code_memory reads, captures the
// returned word one cycle later and queues it for the decoder.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter int          DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter int unsigned START_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] out_code_addr,
    input  logic [DATA_WIDTH-1:0] in_code_data,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_instr_pc,
    output logic                  out_instr_valid,
    input  logic                  in_instr_ready,
    input  logic                  in_jump_en,
    input  logic [ADDR_WIDTH-1:0] in_jump_addr,
    input  logic                  in_halt,
    input  logic                  in_resume,
    output logic                  out_halted
);

    fetch_state_t          state_r;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic                  inflight_r;
    logic [ADDR_WIDTH-1:0] inflight_pc_r;
    logic                  halted_r;

    logic [1:0]            count_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  issue_s;
    logic [2:0]            occupancy_s;

    assign out_code_addr   = pc_r;
    assign out_instr_valid = !empty_s;
    assign out_halted      = halted_r;

    assign pop_s       = out_instr_valid && in_instr_ready;
    assign push_s      = inflight_r && !in_jump_en;
    assign occupancy_s = {1'b0, count_s} + {2'b00, inflight_r};

    // Only issue when the word can be guaranteed a queue slot on its return.
    assign issue_s = (state_r == ST_RUN) && !in_jump_en && !in_halt &&
                     (occupancy_s < (3'(QUEUE_DEPTH) + {2'b00, pop_s}));

    // Control FSM: PC, in-flight tracking and halted flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            pc_r          <= ADDR_WIDTH'(START_ADDR);
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
            halted_r      <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            case (state_r)
                ST_IDLE: begin
                    state_r  <= ST_RUN;
                    halted_r <= 1'b0;
                    if (in_jump_en) begin
                        pc_r <= in_jump_addr;
                    end
                end
                ST_RUN: begin
                    if (in_jump_en) begin
                        pc_r     <= in_jump_addr;
                        halted_r <= 1'b0;
                    end else if (in_halt) begin
                        state_r  <= ST_HALTED;
                        halted_r <= 1'b1;
                    end else if (issue_s) begin
                        inflight_pc_r <= pc_r;
                        pc_r          <= pc_r + ADDR_WIDTH'(1);
                        halted_r      <= 1'b0;
                    end else begin
                        halted_r <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    if (in_jump_en) begin
                        pc_r     <= in_jump_addr;
                        state_r  <= ST_RUN;
                        halted_r <= 1'b0;
                    end else if (in_resume) begin
                        state_r  <= ST_RUN;
                        halted_r <= 1'b0;
                    end else begin
                        halted_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    fetch_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .flush      (in_jump_en),
        .push       (push_s),
        .push_instr (in_code_data),
        .push_pc    (inflight_pc_r),
        .pop        (pop_s),
        .head_instr (out_instr),
        .head_pc    (out_instr_pc),
        .count      (count_s),
        .full       (full_s),
        .empty      (empty_s)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural one-cycle-latency code memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  out_code_addr;
    logic [15:0] in_code_data;
    logic [15:0] out_instr;
    logic [8:0]  out_instr_pc;
    logic        out_instr_valid;
    logic        in_instr_ready = 1'b0;
    logic        in_jump_en = 1'b0;
    logic [8:0]  in_jump_addr = 9'h000;
    logic        in_halt = 1'b0;
    logic        in_resume = 1'b0;
    logic        out_halted;

    logic [15:0] mem [512];
    int pass_cnt = 0;
    int chk_cnt = 0;
    int overflow_cnt = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_WIDTH (9),
        .DATA_WIDTH (16),
        .START_ADDR (0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .out_code_addr   (out_code_addr),
        .in_code_data    (in_code_data),
        .out_instr       (out_instr),
        .out_instr_pc    (out_instr_pc),
        .out_instr_valid (out_instr_valid),
        .in_instr_ready  (in_instr_ready),
        .in_jump_en      (in_jump_en),
        .in_jump_addr    (in_jump_addr),
        .in_halt         (in_halt),
        .in_resume       (in_resume),
        .out_halted      (out_halted)
    );

    // Code memory: registered read of the sampled address.
    always @(posedge clk) in_code_data <= mem[out_code_addr];

    // A fetch returning into a full queue with nothing leaving would overflow.
    always @(negedge clk) begin
        if (!reset && dut.inflight_r && dut.u_buffer.full && !(out_instr_valid && in_instr_ready))
            overflow_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [15:0] instr, input logic [8:0] pc);
        check_eq({tag, "_valid"}, {31'd0, out_instr_valid}, 32'd1);
        check_eq({tag, "_instr"}, {16'd0, out_instr}, {16'd0, instr});
        check_eq({tag, "_pc"}, {23'd0, out_instr_pc}, {23'd0, pc});
    endtask

    task automatic hold_reset(input logic ready);
        reset = 1'b1;
        in_instr_ready = ready;
        in_jump_en = 1'b0;
        in_halt = 1'b0;
        in_resume = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic startup(input string tag);
        hold_reset(1'b1);
        check_eq({tag, "_rst_valid"}, {31'd0, out_instr_valid}, 32'd0);
        check_eq({tag, "_rst_addr"}, {23'd0, out_code_addr}, 32'd0);
        check_eq({tag, "_rst_halted"}, {31'd0, out_halted}, 32'd0);
        step();
        check_eq({tag, "_idle_addr"}, {23'd0, out_code_addr}, 32'd0);
        check_eq({tag, "_idle_valid"}, {31'd0, out_instr_valid}, 32'd0);
        step();
        check_eq({tag, "_issue_addr"}, {23'd0, out_code_addr}, 32'd1);
        check_eq({tag, "_issue_valid"}, {31'd0, out_instr_valid}, 32'd0);
        step();
        check_head({tag, "_c3"}, 16'hF0F0, 9'd0);
        step();
        check_head({tag, "_c4"}, 16'h0F0F, 9'd1);
        step();
        check_head({tag, "_c5"}, 16'h1234, 9'd2);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'hA000 | 16'(i);
        mem[0] = 16'hF0F0;
        mem[1] = 16'h0F0F;
        mem[2] = 16'h1234;

        // Basic startup with ready held high.
        startup("s1");

        // Reset while a word is valid and a fetch is in flight.
        #2 reset = 1'b1;
        #1;
        check_eq("arst_valid", {31'd0, out_instr_valid}, 32'd0);
        check_eq("arst_instr", {16'd0, out_instr}, 32'd0);
        check_eq("arst_pc", {23'd0, out_instr_pc}, 32'd0);
        check_eq("arst_addr", {23'd0, out_code_addr}, 32'd0);
        startup("s6");

        // Backpressure: queue fills, PC stops, then drains without gap.
        hold_reset(1'b0);
        for (int i = 0; i < 6; i++) step();
        check_eq("bp_addr", {23'd0, out_code_addr}, 32'd2);
        check_head("bp_full", 16'hF0F0, 9'd0);
        in_instr_ready = 1'b1;
        step();
        check_head("bp_d1", 16'h0F0F, 9'd1);
        step();
        check_head("bp_d2", 16'h1234, 9'd2);
        step();
        check_head("bp_d3", 16'hA003, 9'd3);

        // Jump with a queued word and a fetch in flight.
        hold_reset(1'b0);
        for (int i = 0; i < 3; i++) step();
        check_head("jmp_pre", 16'hF0F0, 9'd0);
        in_jump_en = 1'b1;
        in_jump_addr = 9'h100;
        step();
        in_jump_en = 1'b0;
        in_instr_ready = 1'b1;
        check_eq("jmp_valid0", {31'd0, out_instr_valid}, 32'd0);
        check_eq("jmp_addr0", {23'd0, out_code_addr}, 32'h100);
        step();
        check_eq("jmp_valid1", {31'd0, out_instr_valid}, 32'd0);
        check_eq("jmp_addr1", {23'd0, out_code_addr}, 32'h101);
        step();
        check_head("jmp_t0", 16'hA100, 9'h100);
        step();
        check_head("jmp_t1", 16'hA101, 9'h101);

        // Jump to the last address; PC wraps to zero.
        in_jump_en = 1'b1;
        in_jump_addr = 9'h1FF;
        step();
        in_jump_en = 1'b0;
        check_eq("wrap_valid0", {31'd0, out_instr_valid}, 32'd0);
        check_eq("wrap_addr0", {23'd0, out_code_addr}, 32'h1FF);
        step();
        check_eq("wrap_addr1", {23'd0, out_code_addr}, 32'h000);
        step();
        check_head("wrap_t0", 16'hA1FF, 9'h1FF);
        step();
        check_head("wrap_t1", 16'hF0F0, 9'h000);

        // Halt at pc 5, drain, then resume from the frozen address.
        hold_reset(1'b1);
        for (int i = 0; i < 6; i++) step();
        check_eq("halt_pre_addr", {23'd0, out_code_addr}, 32'd5);
        check_head("halt_pre", 16'hA003, 9'd3);
        in_halt = 1'b1;
        step();
        in_halt = 1'b0;
        check_eq("halt_flag1", {31'd0, out_halted}, 32'd1);
        check_eq("halt_addr1", {23'd0, out_code_addr}, 32'd5);
        check_head("halt_drain", 16'hA004, 9'd4);
        step();
        check_eq("halt_valid2", {31'd0, out_instr_valid}, 32'd0);
        check_eq("halt_addr2", {23'd0, out_code_addr}, 32'd5);
        step();
        check_eq("halt_flag3", {31'd0, out_halted}, 32'd1);
        check_eq("halt_addr3", {23'd0, out_code_addr}, 32'd5);
        in_resume = 1'b1;
        step();
        in_resume = 1'b0;
        check_eq("res_flag", {31'd0, out_halted}, 32'd0);
        check_eq("res_addr0", {23'd0, out_code_addr}, 32'd5);
        step();
        check_eq("res_addr1", {23'd0, out_code_addr}, 32'd6);
        step();
        check_head("res_t0", 16'hA005, 9'd5);

        check_eq("no_overflow", overflow_cnt, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of code_memory and directly downstream-facing to the decoder.
- Owns the program counter, drives the code_memory address, and captures the 16-bit word returned one clock later.
- Buffers fetched words in a 2-entry queue and presents them to the decoder over a valid/ready handshake.
- Supports jumps (flush and redirect), halt, and resume.

Parameters:
- ADDR_WIDTH, 9, code address width; matches code_memory in_addr.
- DATA_WIDTH, 16, instruction width; matches code_memory out_data.
- START_ADDR, 0, PC value loaded at reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- out_code_addr  output  ADDR_WIDTH  address to code_memory in_addr; always equals the PC register.
- in_code_data  input  DATA_WIDTH  code_memory out_data; valid the cycle after the address was sampled.
- out_instr  output  DATA_WIDTH  instruction at queue head.
- out_instr_pc  output  ADDR_WIDTH  address the head instruction was fetched from.
- out_instr_valid  output  1  head entry valid.
- in_instr_ready  input  1  decoder accepts the head; transfer occurs when valid && ready.
- in_jump_en  input  1  redirect request, single-cycle pulse.
- in_jump_addr  input  ADDR_WIDTH  jump target.
- in_halt  input  1  decoder saw a halt instruction; stop fetching.
- in_resume  input  1  leave HALTED.
- out_halted  output  1  high while in HALTED.

Behaviour:
- Reset (async, active-high):
  - pc=START_ADDR; state=IDLE.
  - Queue empty; inflight=0.
  - out_instr=0, out_instr_pc=0, out_instr_valid=0, out_halted=0.
- States:
  - IDLE: one cycle after reset deassertion, no issue. Then RUN.
  - RUN: issue when the issue rule below holds. On in_halt, go to HALTED. On in_jump_en, stay in RUN with a redirect.
  - HALTED: no issue. in_resume returns to RUN. in_jump_en redirects and returns to RUN.
- Memory timing:
  - code_memory samples out_code_addr on the edge.
  - in_code_data is valid for that address in the following cycle.
  - inflight and inflight_pc record an issued fetch. On the next cycle the word is pushed into the queue with tag inflight_pc, unless it was cancelled.
- Issue rule: in RUN, with no jump, no halt this cycle, and (count + inflight - pop) < 2, where pop = out_instr_valid && in_instr_ready.
  - On issue: inflight<=1, inflight_pc<=pc, pc<=pc+1.
  - pc wraps modulo 2^ADDR_WIDTH (511 -> 0).
- Throughput: with ready held high, one instruction per cycle in steady state.
- Latency: first out_instr_valid=1 two cycles after first issue, i.e. the 3rd rising edge after reset deassertion (IDLE, issue, capture).
- Queue: 2 entries of {instr, pc}. out_* are registered from the head.
  - Push and pop in the same cycle are both allowed.
  - A push never occurs into a full queue; the issue rule guarantees this, and the bench asserts it.
- Jump (in_jump_en=1):
  - pc<=in_jump_addr.
  - Queue flushed; the in-flight fetch is cancelled and its data never enters the queue.
  - out_instr_valid=0 the next cycle.
  - A handshake completing in the same cycle as the jump is still a valid transfer.
  - First target instruction is valid 2 cycles after the jump cycle.
- Halt: stop issuing immediately. The already in-flight word is still captured and the queue drains normally. out_halted=1 from the next cycle.
- Priority: reset > jump > halt > resume > normal issue.
- Reset mid-operation: all state is cleared asynchronously; stale in_code_data after reset is ignored because inflight=0.

Decomposition:
- Package fetch_pkg holds the state encoding (IDLE, RUN, HALTED), ADDR_WIDTH/DATA_WIDTH defaults, and the queue depth constant (2).
- Sub-module fetch_buffer: 2-entry FIFO with push/pop, count, full/empty, and a synchronous flush input. It is instantiated once.

Test Plan:
- Memory {0:16'hF0F0, 1:16'h0F0F, 2:16'h1234}, ready=1, release reset -> cycles 3/4/5 show instr F0F0/0F0F/1234 with pc 0/1/2 and valid held high.
- Ready=0 after reset for 6 cycles -> queue holds F0F0 and 0F0F, out_code_addr stops at 2, no overflow; ready=1 -> 1234 follows with no gap or duplicate.
- Jump to 9'h100 while queue full and a fetch in flight -> valid=0 next cycle; the next valid instr is mem[0x100] with pc=0x100; old words are never presented.
- Jump to 9'h1FF, ready=1 -> pc sequence 0x1FF then 0x000 (wrap), data matches memory.
- in_halt at pc=5 -> the in-flight word and queue drain, out_halted=1, out_code_addr is frozen; in_resume -> fetching continues at the frozen address.
- Assert reset while valid=1 and inflight=1 -> all outputs are 0 immediately (asynchronous), and the restart sequence matches the first scenario.
